width_12to8: RTL

- Unpacks a stream of 12-bit words into an MSB-first stream of 8-bit bytes.
- Sits directly downstream of the 8-to-12 packer and consumes its 12-bit words.
- Nibble-granular 24-bit residue buffer; valid/ready handshake on both sides.
- Supports packet termination: a final odd nibble is zero-padded and the last byte is flagged.

---
 rtl/width_12to8_if.sv | 21 ++
 rtl/width_12to8.sv | 79 +++++++
 2 files changed

// File: rtl/width_12to8_if.sv
// rtl/width_12to8_if.sv - handshake bundle between the 12-bit word source and the 8-bit byte sink
interface width_12to8_if;
  logic        valid_in;
  logic        ready_in;
  logic [11:0] data_in;
  logic        last_in;
  logic        valid_out;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        last_out;

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out
  );

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out
  );
endinterface

// File: rtl/width_12to8.sv
// rtl/width_12to8.sv - unpacks 12-bit words into an MSB-first byte stream
// Nibble-granular 24-bit residue buffer; odd-length packets are zero-padded.
module width_12to8 (
  input  logic          clk,
  input  logic          rst_n,
  width_12to8_if.slave  bus
);

  logic [23:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_pend_q, last_pend_d;

  logic        valid_o_int;
  logic        ready_i_int;
  logic        last_o_int;
  logic        in_fire;
  logic        out_fire;

  function automatic logic [4:0] nib_sh(input logic [2:0] n);
    return {n, 2'b00};
  endfunction

  // Handshake outputs depend on state only, never on the same-cycle inputs.
  assign valid_o_int = (cnt_q >= 3'd2);
  assign last_o_int  = last_pend_q && (cnt_q == 3'd2);
  assign ready_i_int = (cnt_q <= 3'd3) && !last_pend_q;

  assign bus.valid_out = valid_o_int;
  assign bus.data_out  = buf_q[23:16];
  assign bus.last_out  = last_o_int;
  assign bus.ready_in  = ready_i_int;

  assign in_fire  = bus.valid_in && ready_i_int;
  assign out_fire = valid_o_int && bus.ready_out;

  always_comb begin
    logic [2:0] c;
    buf_d       = buf_q;
    last_pend_d = last_pend_q;
    c           = cnt_q;

    if (out_fire) begin
      buf_d = {buf_q[15:0], 8'h00};
      c     = cnt_q - 3'd2;
      if (last_o_int) begin
        last_pend_d = 1'b0;
      end
    end

    // Shift happens first, so a word accepted alongside a byte lands behind the survivors.
    if (in_fire) begin
      buf_d = buf_d | ({bus.data_in, 12'h000} >> nib_sh(c));
      c     = c + 3'd3;
      if (bus.last_in) begin
        last_pend_d = 1'b1;
        if (c[0]) begin
          buf_d = buf_d & ~(24'hF0_0000 >> nib_sh(c));
          c     = c + 3'd1;
        end
      end
    end

    buf_d = buf_d & ~(24'hFF_FFFF >> nib_sh(c));
    cnt_d = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= 24'h00_0000;
      cnt_q       <= 3'd0;
      last_pend_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
    end
  end

endmodule
